// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes, port
// indices, funct3 access-size codes and a small grant helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Requester indices into the one-hot grant vector
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // funct3 size/sign codes carried on the mask lines
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // One-hot grant for a port index (0 -> 2'b01, 1 -> 2'b10)
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two data-memory requesters.
// With rr_en_i low port 0 always wins a collision; with rr_en_i high the
// port that was not granted last (last_i holds its index) wins.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic [1:0] grant_o
);

  // Single requester takes it; a collision goes to the fixed or rotating favourite
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = port_onehot(1'b0);
      2'b10:   grant_o = port_onehot(1'b1);
      2'b11:   grant_o = port_onehot(rr_en_i & ~last_i);
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory load/store port.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA loader. One access
// is in flight at a time: IDLE picks and latches a request, ISSUE drives a
// one-cycle enable, WAIT tracks the memory busy line (with a timeout), RESP
// pulses the winner's ack with read data or an error.
// Build option: define DMEM_ARB_RR_EN for round-robin contention resolution;
// without it port 0 has fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  input  logic [2:0]        p0_mask_i,
  output logic              p0_ack_o,
  output logic [31:0]       p0_rdata_o,
  output logic              p0_err_o,
  output logic              p0_stall_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  input  logic [2:0]        p1_mask_i,
  output logic              p1_ack_o,
  output logic [31:0]       p1_rdata_o,
  output logic              p1_err_o,
  output logic              p1_stall_o,
  output logic              mem_r_ena_o,
  output logic              mem_w_ena_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [2:0]        mem_mask_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_busy_i,
  output logic [1:0]        grant_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              seen_busy_q, seen_busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        mask_q, mask_d;
  logic [1:0]        pick_gnt;
  logic              pick_dbg;
  logic              in_resp;

  dmem_arb_pick u_pick (
    .req_i   ({p1_req_i, p0_req_i}),
    .last_i  (last_q),
    .rr_en_i (RR_EN),
    .grant_o (pick_gnt)
  );

  assign pick_dbg = pick_gnt[PORT_DBG];

  // Next-state and next-payload selection for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    seen_busy_d = seen_busy_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rdata_d     = rdata_q;

    case (state_q)
      ARB_IDLE: begin
        // A busy memory here means an access abandoned by reset is still
        // draining; nothing new may be issued until it finishes.
        if (!mem_busy_i && (p0_req_i || p1_req_i)) begin
          grant_d     = pick_gnt;
          we_d        = pick_dbg ? p1_we_i    : p0_we_i;
          addr_d      = pick_dbg ? p1_addr_i  : p0_addr_i;
          wdata_d     = pick_dbg ? p1_wdata_i : p0_wdata_i;
          mask_d      = pick_dbg ? p1_mask_i  : p0_mask_i;
          seen_busy_d = 1'b0;
          cnt_d       = '0;
          err_d       = 1'b0;
          rdata_d     = '0;
          state_d     = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        state_d = ARB_WAIT;
      end

      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_busy_i) begin
          seen_busy_d = 1'b1;
        end
        // A completion seen on the last allowed cycle still counts as success
        if (seen_busy_q && !mem_busy_i) begin
          rdata_d = we_q ? 32'h0 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end
      end

      ARB_RESP: begin
        last_d  = grant_q[PORT_DBG];
        grant_d = 2'b00;
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Control registers: FSM state, owner, round-robin pointer, timeout tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      seen_busy_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      seen_busy_q <= seen_busy_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Latched access payload; cleared on reset so the memory-side outputs read zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_resp     = (state_q == ARB_RESP);

  assign mem_r_ena_o = (state_q == ARB_ISSUE) & ~we_q;
  assign mem_w_ena_o = (state_q == ARB_ISSUE) &  we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_mask_o  = mask_q;
  assign grant_o     = grant_q;

  assign p0_ack_o    = in_resp & grant_q[PORT_CPU];
  assign p1_ack_o    = in_resp & grant_q[PORT_DBG];
  assign p0_rdata_o  = p0_ack_o ? rdata_q : 32'h0;
  assign p1_rdata_o  = p1_ack_o ? rdata_q : 32'h0;
  assign p0_err_o    = p0_ack_o & err_q;
  assign p1_err_o    = p1_ack_o & err_q;
  assign p0_stall_o  = p0_req_i & ~p0_ack_o;
  assign p1_stall_o  = p1_req_i & ~p1_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized two-port traffic against a transaction-level reference model
// and a behavioural memory with a variable busy time.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [2:0]  p0_mask = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [2:0]  p1_mask = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;

  logic        p0_ack, p0_err, p0_stall, p1_ack, p1_err, p1_stall;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_r_ena, mem_w_ena;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_mask;
  logic [1:0]  grant;

  dmem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_mask_i   (p0_mask),
    .p0_ack_o    (p0_ack),
    .p0_rdata_o  (p0_rdata),
    .p0_err_o    (p0_err),
    .p0_stall_o  (p0_stall),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_mask_i   (p1_mask),
    .p1_ack_o    (p1_ack),
    .p1_rdata_o  (p1_rdata),
    .p1_err_o    (p1_err),
    .p1_stall_o  (p1_stall),
    .mem_r_ena_o (mem_r_ena),
    .mem_w_ena_o (mem_w_ena),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_mask_o  (mem_mask),
    .mem_rdata_i (mem_rdata),
    .mem_busy_i  (mem_busy),
    .grant_o     (grant)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Reference model state (transaction level)
  bit          m_active  = 1'b0;
  bit          m_en_pend = 1'b0;
  bit          m_ack_pend = 1'b0;
  int          m_en_cyc  = 0;
  int          m_ack_cyc = 0;
  int          m_win     = 0;
  bit          m_last    = 1'b1;
  bit          m_we      = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [2:0]  m_mask = '0;
  logic [31:0] m_exp_rdata = '0;
  bit          m_exp_err = 1'b0;
  int          n_acc = 0;

  // Behavioural memory state and directed-test overrides
  int          mem_cnt = 0;
  logic [31:0] mem_val = '0;
  int          force_B = -1;
  bit          force_rd = 1'b0;
  logic [31:0] force_rdval = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Winner for a set of pending requests, from the contention rule
  function automatic int model_pick(input logic [1:0] req, input bit last);
    bit rr;
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return (rr && !last) ? 1 : 0;
  endfunction

  // Busy duration: mostly short, sometimes never (timeout) or longer than the timeout
  function automatic int rand_busy();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 0;
    if (r == 1) return TO;
    if (r == 2) return TO + 2;
    return int'($urandom_range(1, 6));
  endfunction

  task automatic monitor_cycle();
    logic [1:0]  req;
    logic [1:0]  exp_gnt;
    bit          en_now, exp_a0, exp_a1;
    int          b;
    req    = {p1_req, p0_req};
    en_now = m_en_pend && (cyc == m_en_cyc);
    check_eq("r_ena", 64'(mem_r_ena), 64'(en_now && !m_we));
    check_eq("w_ena", 64'(mem_w_ena), 64'(en_now && m_we));
    if (en_now) begin
      check_eq("mem_addr",  64'(mem_addr),  64'(m_addr));
      check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      check_eq("mem_mask",  64'(mem_mask),  64'(m_mask));
      b       = (force_B >= 0) ? force_B : rand_busy();
      mem_cnt = b;
      mem_val = force_rd ? force_rdval : $urandom;
      if (b == 0 || b >= TO) begin
        m_ack_cyc   = cyc + TO + 1;
        m_exp_err   = 1'b1;
        m_exp_rdata = 32'h0;
      end else begin
        m_ack_cyc   = cyc + b + 2;
        m_exp_err   = 1'b0;
        m_exp_rdata = m_we ? 32'h0 : mem_val;
      end
      m_en_pend  = 1'b0;
      m_ack_pend = 1'b1;
    end
    exp_gnt = m_active ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
    check_eq("grant", 64'(grant), 64'(exp_gnt));
    exp_a0 = m_ack_pend && (cyc == m_ack_cyc) && (m_win == 0);
    exp_a1 = m_ack_pend && (cyc == m_ack_cyc) && (m_win == 1);
    check_eq("p0_ack",   64'(p0_ack),   64'(exp_a0));
    check_eq("p1_ack",   64'(p1_ack),   64'(exp_a1));
    check_eq("p0_rdata", 64'(p0_rdata), 64'(exp_a0 ? m_exp_rdata : 32'h0));
    check_eq("p1_rdata", 64'(p1_rdata), 64'(exp_a1 ? m_exp_rdata : 32'h0));
    check_eq("p0_err",   64'(p0_err),   64'(exp_a0 && m_exp_err));
    check_eq("p1_err",   64'(p1_err),   64'(exp_a1 && m_exp_err));
    check_eq("p0_stall", 64'(p0_stall), 64'(p0_req && !exp_a0));
    check_eq("p1_stall", 64'(p1_stall), 64'(p1_req && !exp_a1));
    if (rst) begin
      m_active   = 1'b0;
      m_en_pend  = 1'b0;
      m_ack_pend = 1'b0;
      m_last     = 1'b1;
    end else if (!m_active && req != 2'b00 && !mem_busy) begin
      m_win     = model_pick(req, m_last);
      m_we      = (m_win == 1) ? p1_we    : p0_we;
      m_addr    = (m_win == 1) ? p1_addr  : p0_addr;
      m_wdata   = (m_win == 1) ? p1_wdata : p0_wdata;
      m_mask    = (m_win == 1) ? p1_mask  : p0_mask;
      m_active  = 1'b1;
      m_en_pend = 1'b1;
      m_en_cyc  = cyc + 1;
    end else if (m_ack_pend && cyc == m_ack_cyc) begin
      m_active   = 1'b0;
      m_ack_pend = 1'b0;
      m_last     = (m_win == 1);
      n_acc++;
    end
  endtask

  // Memory busy/rdata driven after each rising edge; monitor samples on the falling edge
  initial begin : mem_and_monitor
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_cnt > 0) begin
        mem_busy  = 1'b1;
        mem_rdata = $urandom;
        mem_cnt--;
      end else begin
        mem_busy  = 1'b0;
        mem_rdata = mem_val;
      end
      @(negedge clk);
      if (mon_en) monitor_cycle();
    end
  end

  task automatic set_port(input int p, input bit req, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] m);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_mask = m;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_mask = m;
    end
  endtask

  task automatic port_txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] m, input bit hold,
                          output logic [31:0] rd, output bit er);
    bit got;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    @(posedge clk); #1;
    set_port(p, 1'b1, we, a, d, m);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? p0_ack : p1_ack;
      rd  = (p == 0) ? p0_rdata : p1_rdata;
      er  = (p == 0) ? p0_err : p1_err;
    end
    check_eq($sformatf("ack_wait_p%0d", p), 64'(got), 64'(1));
    if (!hold) begin
      @(posedge clk); #1;
      set_port(p, 1'b0, we, a, d, m);
    end
  endtask

  task automatic rand_port(input int p, input int n);
    bit          hold;
    logic [31:0] rd;
    bit          er;
    hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      hold = ($urandom_range(0, 3) == 0) && (i != n - 1);
      port_txn(p, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
               3'($urandom_range(0, 7)), hold, rd, er);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !m_active && !mem_busy;
    end
    check_eq(tag, 64'(idle), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd0, rd1;
    bit          er0, er1;
    int          acc_before;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", 64'(grant),     64'(0));
    check_eq("rst_r_ena", 64'(mem_r_ena), 64'(0));
    check_eq("rst_w_ena", 64'(mem_w_ena), 64'(0));
    check_eq("rst_addr",  64'(mem_addr),  64'(0));
    check_eq("rst_wdata", 64'(mem_wdata), 64'(0));
    check_eq("rst_mask",  64'(mem_mask),  64'(0));
    check_eq("rst_ack0",  64'(p0_ack),    64'(0));
    check_eq("rst_ack1",  64'(p1_ack),    64'(0));
    check_eq("rst_rdata0", 64'(p0_rdata), 64'(0));
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Collision straight out of reset: port 0 first in either mode
    fork
      port_txn(0, 1'b0, 32'h0000_0100, 32'h0,         F3_LW, 1'b0, rd0, er0);
      port_txn(1, 1'b1, 32'h0000_0200, 32'h1234_5678, F3_SW, 1'b0, rd1, er1);
    join

    // p0 load, memory busy 3 cycles
    force_B = 3; force_rd = 1'b1; force_rdval = 32'hDEAD_BEEF;
    port_txn(0, 1'b0, 32'h0000_1004, 32'h0, F3_LW, 1'b0, rd0, er0);
    check_eq("t1_rdata", 64'(rd0), 64'(32'hDEAD_BEEF));
    check_eq("t1_err",   64'(er0), 64'(0));
    force_rd = 1'b0;

    // Second collision after a port-0 grant: round-robin hands it to port 1
    force_B = 2;
    fork
      port_txn(0, 1'b0, 32'h0000_0300, 32'h0, F3_LH, 1'b0, rd0, er0);
      port_txn(1, 1'b0, 32'h0000_0304, 32'h0, F3_LB, 1'b0, rd1, er1);
    join

    // p1 byte store
    port_txn(1, 1'b1, 32'h0000_2000, 32'h0000_00A5, F3_SB, 1'b0, rd1, er1);
    check_eq("t3_rdata", 64'(rd1), 64'(0));
    check_eq("t3_err",   64'(er1), 64'(0));

    // Memory never goes busy: timeout with error
    force_B = 0;
    port_txn(0, 1'b0, 32'h0000_0040, 32'h0, F3_LW, 1'b0, rd0, er0);
    check_eq("t4_err",   64'(er0), 64'(1));
    check_eq("t4_rdata", 64'(rd0), 64'(0));

    // Back-to-back requests held high across the ack
    force_B = 1;
    port_txn(0, 1'b0, 32'h0000_0080, 32'h0,         F3_LW, 1'b1, rd0, er0);
    port_txn(0, 1'b1, 32'h0000_0084, 32'hCAFE_F00D, F3_SW, 1'b0, rd0, er0);

    // Request withdrawn mid-access: access still completes
    acc_before = n_acc;
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, F3_LBU);
    repeat (3) @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, 32'h0000_0500, 32'h0, F3_LBU);
    wait_idle("viol_idle");
    check_eq("viol_done", 64'(n_acc), 64'(acc_before + 1));

    // Reset during WAIT while memory is busy
    force_B = 8;
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, F3_LW);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    force_B = 2;
    @(negedge clk);
    check_eq("mrst_grant", 64'(grant),     64'(0));
    check_eq("mrst_addr",  64'(mem_addr),  64'(0));
    check_eq("mrst_wdata", 64'(mem_wdata), 64'(0));
    check_eq("mrst_mask",  64'(mem_mask),  64'(0));
    port_txn(1, 1'b0, 32'h0000_0600, 32'h0, F3_LHU, 1'b0, rd1, er1);
    check_eq("mrst_err", 64'(er1), 64'(0));

    // Randomized concurrent traffic
    force_B = -1;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    wait_idle("drain_idle");
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
